rx_data_sampler: RTL

- Oversampling front end of the UART receiver.
- Synchronises the raw serial line and counts oversampling edges within each bit period.
- Takes three samples around the bit centre and majority-votes them.
- Delivers the resolved `sampled_bit` with a one-cycle `sample_valid` strobe to the downstream RX stages: start check, deserializer, parity check and stop check.

---
 rtl/rx_data_sampler_if.sv | 23 ++
 rtl/rx_data_sampler.sv | 111 +++++++++++
 2 files changed

// File: rtl/rx_data_sampler_if.sv
// Serial-line sampling bus between the UART RX controller and the oversampling front end.
// The master drives the line, prescale and enable; the sampler returns the voted bit and timing strobes.
interface rx_data_sampler_if #(
  parameter int PRESC_W = 6
);
  logic               RX_IN;
  logic [PRESC_W-1:0] Prescale;
  logic               dat_samp_en;
  logic               sampled_bit;
  logic               sample_valid;
  logic [PRESC_W-1:0] edge_cnt;
  logic               bit_done;

  modport master (
    output RX_IN, Prescale, dat_samp_en,
    input  sampled_bit, sample_valid, edge_cnt, bit_done
  );

  modport slave (
    input  RX_IN, Prescale, dat_samp_en,
    output sampled_bit, sample_valid, edge_cnt, bit_done
  );
endinterface

// File: rtl/rx_data_sampler.sv
// UART RX oversampling front end: synchronises RX_IN, counts edges per bit and
// majority-votes three samples around the bit centre.
module rx_data_sampler #(
  parameter int PRESC_W = 6
) (
  input logic              CLK,
  input logic              RST,
  rx_data_sampler_if.slave bus
);

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               rx_s;
  logic [PRESC_W-1:0] edge_cnt_q, edge_cnt_d;
  logic               s0_q, s0_d;
  logic               s1_q, s1_d;
  logic               s2_q, s2_d;
  logic               sampled_bit_q, sampled_bit_d;
  logic               sample_valid_q, sample_valid_d;
  logic               bit_done_q, bit_done_d;

  logic [PRESC_W-1:0] last_idx;
  logic [PRESC_W-1:0] s0_idx;
  logic [PRESC_W-1:0] s1_idx;
  logic [PRESC_W-1:0] s2_idx;
  logic [PRESC_W-1:0] vote_idx;

  assign rx_s = sync2_q;

  // Unsupported prescale values fall back to 8x oversampling.
  always_comb begin
    case (bus.Prescale)
      PRESC_W'(16): begin
        last_idx = PRESC_W'(15);
        s0_idx   = PRESC_W'(7);
        s1_idx   = PRESC_W'(8);
        s2_idx   = PRESC_W'(9);
        vote_idx = PRESC_W'(10);
      end
      PRESC_W'(32): begin
        last_idx = PRESC_W'(31);
        s0_idx   = PRESC_W'(15);
        s1_idx   = PRESC_W'(16);
        s2_idx   = PRESC_W'(17);
        vote_idx = PRESC_W'(18);
      end
      default: begin
        last_idx = PRESC_W'(7);
        s0_idx   = PRESC_W'(3);
        s1_idx   = PRESC_W'(4);
        s2_idx   = PRESC_W'(5);
        vote_idx = PRESC_W'(6);
      end
    endcase
  end

  always_comb begin
    sync1_d        = bus.RX_IN;
    sync2_d        = sync1_q;
    edge_cnt_d     = '0;
    s0_d           = 1'b0;
    s1_d           = 1'b0;
    s2_d           = 1'b0;
    sampled_bit_d  = sampled_bit_q;
    sample_valid_d = 1'b0;
    bit_done_d     = 1'b0;

    // Dropping the enable discards the partial bit: counter and samples clear.
    if (bus.dat_samp_en) begin
      edge_cnt_d = (edge_cnt_q >= last_idx) ? '0 : edge_cnt_q + PRESC_W'(1);
      s0_d       = (edge_cnt_q == s0_idx) ? rx_s : s0_q;
      s1_d       = (edge_cnt_q == s1_idx) ? rx_s : s1_q;
      s2_d       = (edge_cnt_q == s2_idx) ? rx_s : s2_q;
      if (edge_cnt_q == vote_idx) begin
        sampled_bit_d  = (s0_q & s1_q) | (s0_q & s2_q) | (s1_q & s2_q);
        sample_valid_d = 1'b1;
      end
      bit_done_d = (edge_cnt_q == last_idx);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q        <= 1'b1;
      sync2_q        <= 1'b1;
      edge_cnt_q     <= '0;
      s0_q           <= 1'b0;
      s1_q           <= 1'b0;
      s2_q           <= 1'b0;
      sampled_bit_q  <= 1'b1;
      sample_valid_q <= 1'b0;
      bit_done_q     <= 1'b0;
    end else begin
      sync1_q        <= sync1_d;
      sync2_q        <= sync2_d;
      edge_cnt_q     <= edge_cnt_d;
      s0_q           <= s0_d;
      s1_q           <= s1_d;
      s2_q           <= s2_d;
      sampled_bit_q  <= sampled_bit_d;
      sample_valid_q <= sample_valid_d;
      bit_done_q     <= bit_done_d;
    end
  end

  assign bus.sampled_bit  = sampled_bit_q;
  assign bus.sample_valid = sample_valid_q;
  assign bus.edge_cnt     = edge_cnt_q;
  assign bus.bit_done     = bit_done_q;

endmodule
